// File: rtl/keypad_scanner.sv
// keypad_scanner: front end of the code-entry lock.
// Strobes one active-low column at a time, samples the active-low rows,
// builds a 16-bit snapshot per full scan and debounces single key presses
// into a one-cycle key_valid pulse with a hex key code.
module keypad_scanner #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 8
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       multi_err
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      HELD
   } state_t;

   logic [3:0]    r_rowMeta;
   logic [3:0]    r_rowSync;
   logic [DW-1:0] r_dwell;
   logic [1:0]    r_col;
   logic [15:0]   r_snap;

   state_t        r_state;
   logic [3:0]    r_cand;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_relCnt;
   logic [3:0]    r_keyCode;
   logic          r_keyValid;
   logic          r_keyHeld;
   logic          r_multiErr;

   state_t        w_state;
   logic [3:0]    w_cand;
   logic [CW-1:0] w_cnt;
   logic [CW-1:0] w_relCnt;
   logic [3:0]    w_keyCode;
   logic          w_keyValid;
   logic          w_keyHeld;
   logic          w_multiErr;

   logic          w_sample;
   logic          w_scanEnd;
   logic [15:0]   w_snapNext;
   logic [4:0]    w_ones;
   logic [3:0]    w_idx;
   logic          w_isNone;
   logic          w_isOne;
   logic          w_isMulti;

   assign w_sample  = (r_dwell == DIV_LAST);
   assign w_scanEnd = w_sample && (r_col == 2'd3);

   assign key_code  = r_keyCode;
   assign key_valid = r_keyValid;
   assign key_held  = r_keyHeld;
   assign multi_err = r_multiErr;

   // Rows are asynchronous to clk_in, so bring them through two flops first
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_rowMeta <= 4'hF;
         r_rowSync <= 4'hF;
      end else begin
         r_rowMeta <= row_in;
         r_rowSync <= r_rowMeta;
      end
   end

   // Active-low one-hot strobe for the column currently being dwelt on
   always_comb begin
      col_out = ~(4'b0001 << r_col);
   end

   // Snapshot with the current column's rows merged in; 1 means pressed
   always_comb begin
      w_snapNext = r_snap;
      for (int r = 0; r < 4; r++) begin
         w_snapNext[{2'(r), r_col}] = ~r_rowSync[r];
      end
   end

   // Classify the completed snapshot and find the index of the lowest set bit
   always_comb begin
      w_ones = 5'd0;
      w_idx  = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (w_snapNext[i]) begin
            w_ones = w_ones + 5'd1;
            w_idx  = 4'(i);
         end
      end
      w_isNone  = (w_ones == 5'd0);
      w_isOne   = (w_ones == 5'd1);
      w_isMulti = (w_ones >= 5'd2);
   end

   // Dwell counter, column rotation and snapshot capture at the end of each dwell
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_dwell <= '0;
         r_col   <= 2'd0;
         r_snap  <= 16'd0;
      end else if (w_sample) begin
         r_dwell <= '0;
         r_col   <= r_col + 2'd1;
         r_snap  <= w_snapNext;
      end else begin
         r_dwell <= r_dwell + 1'b1;
      end
   end

   // Debounce FSM state and output registers
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_cand     <= 4'd0;
         r_cnt      <= '0;
         r_relCnt   <= '0;
         r_keyCode  <= 4'd0;
         r_keyValid <= 1'b0;
         r_keyHeld  <= 1'b0;
         r_multiErr <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_cand     <= w_cand;
         r_cnt      <= w_cnt;
         r_relCnt   <= w_relCnt;
         r_keyCode  <= w_keyCode;
         r_keyValid <= w_keyValid;
         r_keyHeld  <= w_keyHeld;
         r_multiErr <= w_multiErr;
      end
   end

   // Next-state logic; every decision happens only at scan end
   always_comb begin
      w_state    = r_state;
      w_cand     = r_cand;
      w_cnt      = r_cnt;
      w_relCnt   = r_relCnt;
      w_keyCode  = r_keyCode;
      w_keyValid = 1'b0;
      w_keyHeld  = r_keyHeld;
      w_multiErr = r_multiErr;
      if (w_scanEnd) begin
         w_multiErr = w_isMulti;
         case (r_state)
            IDLE: begin
               if (w_isOne) begin
                  if (DEB_MAX == CW'(1)) begin
                     w_keyValid = 1'b1;
                     w_keyCode  = w_idx;
                     w_keyHeld  = 1'b1;
                     w_relCnt   = '0;
                     w_cnt      = '0;
                     w_state    = HELD;
                  end else begin
                     w_cand  = w_idx;
                     w_cnt   = CW'(1);
                     w_state = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (w_isOne && (w_idx == r_cand)) begin
                  if (r_cnt + 1'b1 == DEB_MAX) begin
                     w_keyValid = 1'b1;
                     w_keyCode  = r_cand;
                     w_keyHeld  = 1'b1;
                     w_relCnt   = '0;
                     w_cnt      = '0;
                     w_state    = HELD;
                  end else begin
                     w_cnt = r_cnt + 1'b1;
                  end
               end else if (w_isOne) begin
                  w_cand = w_idx;
                  w_cnt  = CW'(1);
               end else begin
                  w_cnt   = '0;
                  w_state = IDLE;
               end
            end
            HELD: begin
               if (w_isNone) begin
                  if (r_relCnt + 1'b1 == DEB_MAX) begin
                     w_keyHeld = 1'b0;
                     w_relCnt  = '0;
                     w_state   = IDLE;
                  end else begin
                     w_relCnt = r_relCnt + 1'b1;
                  end
               end else begin
                  w_relCnt = '0;
               end
            end
            default: begin
               w_state = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4 and
// DEBOUNCE_SCANS=2, so one full scan is 16 clocks. A small keypad model pulls a
// row low whenever a pressed key sits in the strobed column.
module tb_keypad_scanner;

   logic        clk_in;
   logic        rst;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic        multi_err;

   logic [15:0] keys;
   int          errorCount;
   int          checkCount;
   int          pulseCount;

   keypad_scanner #(
      .SCAN_DIV      (4),
      .DEBOUNCE_SCANS(2)
   ) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .row_in   (row_in),
      .col_out  (col_out),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held),
      .multi_err(multi_err)
   );

   // Free-running clock, posedges at 5, 15, 25 ...
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // Keypad model: a pressed key shorts its row to the strobed (low) column
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
         end
      end
   end

   // Count every key_valid cycle to prove single pulses
   always @(posedge clk_in) begin
      if (key_valid) pulseCount <= pulseCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checkCount++;
      assert (obs === exp)
      else begin
         errorCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic scans(input int n);
      repeat (16 * n) @(negedge clk_in);
   endtask

   task automatic applyStimulus(input logic [15:0] k);
      keys = k;
   endtask

   // Directed sequence; after a release at a negedge, scan ends fall on posedge 16k
   initial begin
      errorCount = 0;
      checkCount = 0;
      pulseCount = 0;
      keys       = 16'h0000;
      rst        = 1'b0;

      step(3);
      checkOutput("reset_col", 16'(col_out), 16'hE);
      checkOutput("reset_code", 16'(key_code), 16'h0);
      checkOutput("reset_valid", 16'(key_valid), 16'h0);
      checkOutput("reset_held", 16'(key_held), 16'h0);
      checkOutput("reset_multi", 16'(multi_err), 16'h0);

      rst = 1'b1;
      step(3);
      checkOutput("col0_dwell", 16'(col_out), 16'hE);
      step(1);
      checkOutput("col1", 16'(col_out), 16'hD);
      step(4);
      checkOutput("col2", 16'(col_out), 16'hB);
      step(4);
      checkOutput("col3", 16'(col_out), 16'h7);
      step(4);
      checkOutput("col_wrap", 16'(col_out), 16'hE);

      // Bounce: key 9 down for one scan only
      applyStimulus(16'h1 << 9);
      scans(1);
      checkOutput("bounce_valid", 16'(key_valid), 16'h0);
      applyStimulus(16'h0000);
      scans(2);
      checkOutput("bounce_pulses", 16'(pulseCount), 16'd0);
      checkOutput("bounce_code", 16'(key_code), 16'h0);
      checkOutput("bounce_held", 16'(key_held), 16'h0);

      // Keys 0 and 5 together for three scans
      applyStimulus(16'h0021);
      scans(1);
      checkOutput("multi_set", 16'(multi_err), 16'h1);
      checkOutput("multi_valid", 16'(key_valid), 16'h0);
      scans(2);
      checkOutput("multi_hold", 16'(multi_err), 16'h1);
      checkOutput("multi_pulses", 16'(pulseCount), 16'd0);
      applyStimulus(16'h0000);
      scans(1);
      checkOutput("multi_clear", 16'(multi_err), 16'h0);

      // Clean press of key 6 for five scans
      applyStimulus(16'h1 << 6);
      scans(1);
      checkOutput("press6_deb_valid", 16'(key_valid), 16'h0);
      checkOutput("press6_deb_held", 16'(key_held), 16'h0);
      scans(1);
      checkOutput("press6_valid", 16'(key_valid), 16'h1);
      checkOutput("press6_code", 16'(key_code), 16'h6);
      checkOutput("press6_held", 16'(key_held), 16'h1);
      step(1);
      checkOutput("press6_pulse_end", 16'(key_valid), 16'h0);
      step(15);
      scans(2);
      checkOutput("press6_pulses", 16'(pulseCount), 16'd1);
      checkOutput("press6_still_held", 16'(key_held), 16'h1);

      // Release: held drops at the second empty scan end
      applyStimulus(16'h0000);
      scans(1);
      checkOutput("release_first", 16'(key_held), 16'h1);
      scans(1);
      checkOutput("release_second", 16'(key_held), 16'h0);
      checkOutput("release_code", 16'(key_code), 16'h6);

      // Re-press key 6 gives a fresh pulse
      applyStimulus(16'h1 << 6);
      scans(2);
      checkOutput("repress_valid", 16'(key_valid), 16'h1);
      step(1);
      checkOutput("repress_pulses", 16'(pulseCount), 16'd2);
      step(15);
      applyStimulus(16'h0000);
      scans(2);
      checkOutput("repress_release", 16'(key_held), 16'h0);

      // Key 3 into DEBOUNCE, then reset mid-scan
      applyStimulus(16'h1 << 3);
      scans(1);
      step(5);
      rst = 1'b0;
      step(2);
      checkOutput("midrst_col", 16'(col_out), 16'hE);
      checkOutput("midrst_code", 16'(key_code), 16'h0);
      checkOutput("midrst_held", 16'(key_held), 16'h0);
      rst = 1'b1;
      scans(1);
      checkOutput("postrst_first_valid", 16'(key_valid), 16'h0);
      checkOutput("postrst_first_code", 16'(key_code), 16'h0);
      scans(1);
      checkOutput("postrst_valid", 16'(key_valid), 16'h1);
      checkOutput("postrst_code", 16'(key_code), 16'h3);
      checkOutput("postrst_held", 16'(key_held), 16'h1);
      step(1);
      checkOutput("postrst_pulse_end", 16'(key_valid), 16'h0);
      checkOutput("postrst_pulses", 16'(pulseCount), 16'd3);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
